// File: rtl/wait_sequencer_pkg.sv
// Shared types and defaults for the wait sequencer: FSM state encoding and
// the default width of the tick count.
package wait_sequencer_pkg;

    localparam int unsigned CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/wait_sequencer_if.sv
// Processor/wait-counter facing signals of the wait sequencer. The slave
// modport is the sequencer itself; master is the surrounding logic.
interface wait_sequencer_if
    import wait_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
);

    logic             start;
    logic [CNT_W-1:0] count;
    logic             abort;
    logic             tick;
    logic             irq_ack;
    logic             tick_en;
    logic             tick_clr;
    logic             busy;
    logic             done;
    logic             irq;
    logic [CNT_W-1:0] remaining;

    modport master (
        output start, count, abort, tick, irq_ack,
        input  tick_en, tick_clr, busy, done, irq, remaining
    );

    modport slave (
        input  start, count, abort, tick, irq_ack,
        output tick_en, tick_clr, busy, done, irq, remaining
    );

endinterface

// File: rtl/wait_sequencer_tick_edge.sv
// Registered rising-edge detector with synchronous clear; a level held high
// produces a single rise pulse.
module tick_edge (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic d_i,
    output logic rise_o
);

    logic q_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            q_q <= 1'b0;
        end else if (clr_i) begin
            q_q <= 1'b0;
        end else begin
            q_q <= d_i;
        end
    end

    assign rise_o = d_i & ~q_q;

endmodule

// File: rtl/wait_sequencer.sv
// Counts N rising edges of the wait counter's terminal count after a single
// start strobe, then pulses done and sets a sticky irq.
module wait_sequencer
    import wait_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    wait_sequencer_if.slave   bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             irq_q, irq_d;
    logic             arm_clr;
    logic             tick_ev;

    // Edge history is wiped in ARM so a stale terminal count is not counted.
    assign arm_clr = (state_q == S_ARM);

    tick_edge u_tick_edge (
        .clk_i   (clock),
        .rst_n_i (reset),
        .clr_i   (arm_clr),
        .d_i     (bus.tick),
        .rise_o  (tick_ev)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.count == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ARM;
                        rem_d   = bus.count;
                    end
                end
            end
            S_ARM: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    rem_d   = '0;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Abort takes priority over a coincident tick event.
                if (bus.abort) begin
                    state_d = S_IDLE;
                    rem_d   = '0;
                end else if (tick_ev && (rem_q != '0)) begin
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                rem_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                rem_d   = '0;
            end
        endcase

        irq_d = irq_q;
        if (bus.irq_ack) begin
            irq_d = 1'b0;
        end
        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            irq_d = 1'b1;
        end
    end

    assign bus.busy      = (state_q == S_ARM) || (state_q == S_RUN);
    assign bus.tick_en   = (state_q == S_RUN);
    assign bus.tick_clr  = (state_q != S_RUN);
    assign bus.done      = (state_q == S_DONE);
    assign bus.irq       = irq_q;
    assign bus.remaining = rem_q;

endmodule

// File: doc/wait_sequencer.md
Name: wait_sequencer

Overview:
- Downstream consumer of the hardware wait counter's terminal-count output (`tick`).
- Lets the processor request a delay of N ticks with one start strobe instead of polling.
- Owns the wait counter's enable and clear lines. Counts terminal-count events and raises a done pulse plus a sticky interrupt flag when N ticks have elapsed.
- Sits between the processor bus-register logic and the wait counter on the FPGA.

Parameters:
- CNT_W, 16, width of the requested tick count and remaining-count readback.

Ports:
- clock  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request strobe; sampled only in IDLE
- count  input  CNT_W  number of ticks to wait; latched on accepted start
- abort  input  1  cancel an active wait
- tick  input  1  terminal-count output of the wait counter (level; may stay high several cycles)
- tick_en  output  1  enable to the wait counter
- tick_clr  output  1  synchronous clear to the wait counter (active-high)
- busy  output  1  high in ARM and RUN
- done  output  1  one-cycle pulse when the wait completes normally
- irq  output  1  sticky completion flag
- irq_ack  input  1  clears irq
- remaining  output  CNT_W  ticks still to wait; 0 when idle

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - tick_en=0, tick_clr=1, busy=0, done=0, irq=0, remaining=0.
  - Edge-detect register tick_q=0.
- States: IDLE, ARM, RUN, DONE.
- IDLE:
  - tick_clr=1, tick_en=0.
  - start=1 with count≠0: latch remaining<=count, go to ARM.
  - start=1 with count=0: go to DONE directly (zero-length wait), no ARM/RUN.
- ARM (exactly 1 cycle):
  - tick_clr=1 so the wait counter restarts from 0 and no stale terminal count is counted.
  - Clear tick_q. Go to RUN.
- RUN:
  - tick_clr=0, tick_en=1.
  - Tick event = tick & ~tick_q, where tick_q is registered tick. A level held high while the counter is stalled counts once.
  - On a tick event, remaining<=remaining-1.
  - If remaining==1 at the event, go to DONE.
- DONE (1 cycle):
  - done=1, irq<=1, tick_en=0, tick_clr=1, remaining=0. Return to IDLE.
- Outputs done, busy, tick_en and tick_clr are registered (decoded from the state register). done is high exactly one cycle.
- Latency:
  - count=1, tick event in RUN cycle k → done high in cycle k+1.
  - Accepted start → first RUN cycle 2 clocks later.
- abort:
  - In ARM or RUN: go to IDLE next cycle. remaining<=0, no done, irq unchanged.
  - In IDLE or DONE: ignored.
- start while busy or in DONE: ignored; count is not re-latched.
- irq:
  - Set on entry to DONE.
  - Cleared by irq_ack in any state.
  - Set wins over simultaneous irq_ack.
- Tick event on the same cycle as abort: abort wins; no decrement.
- remaining is never decremented below 0 and never wraps.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, ARM=2'd1, RUN=2'd2, DONE=2'd3) and the CNT_W default.
- One sub-module is natural: tick_edge (registered rising-edge detector with synchronous clear, 1-bit), reused for other pulse inputs.
- The wait counter itself is instantiated at the top level, not inside this block.

Test Plan:
- Reset: hold reset=0 mid-RUN with remaining=5 → immediately busy=0, tick_en=0, tick_clr=1, irq=0, remaining=0; after release, state is IDLE.
- Basic wait: start with count=3, three single-cycle tick pulses spaced 10 clocks apart → remaining goes 3,2,1,0. done pulses once the cycle after the 3rd pulse, irq=1, busy=0.
- Held tick: count=2, tick held high 5 cycles, then low, then one more pulse → only 2 events counted; done after the second rising edge.
- Zero count: start with count=0 → done one cycle later, tick_en never asserted, irq=1.
- Abort: count=4, abort after 1 tick, with a tick pulse on the same cycle as abort → remaining=0, busy=0, no done, irq unchanged. A new start with count=1 then completes normally.
- irq handshake: irq_ack on the same cycle as DONE entry → irq=1. A later irq_ack → irq=0. A start asserted during RUN is ignored (remaining unchanged).
